// File: rtl/vram_bus_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vram_bus_responder_pkg
//  Purpose  : Shared types, address map constants and the address decode
//             helper for the video-memory bus responder.
//             Window 0x06xx_xxxx holds four word-addressed regions:
//             PARAM (0x0600_0000), MAP (0x0610_0000), TILE (0x0620_0000),
//             PAL (0x0630_0000). The word offset is addr[19:0].
//  Revision : 1.0 - initial release
// ============================================================================
package vram_bus_responder_pkg;

    typedef enum logic [1:0] {
        REG_PARAM = 2'd0,
        REG_MAP   = 2'd1,
        REG_TILE  = 2'd2,
        REG_PAL   = 2'd3
    } vram_region_e;

    localparam logic [31:0] C_VRAM_BASE  = 32'h0600_0000;
    localparam logic [31:0] C_PARAM_BASE = 32'h0600_0000;
    localparam logic [31:0] C_MAP_BASE   = 32'h0610_0000;
    localparam logic [31:0] C_TILE_BASE  = 32'h0620_0000;
    localparam logic [31:0] C_PAL_BASE   = 32'h0630_0000;

    localparam int C_PARAM_WORDS = 660;    // 128 sprites * 5 + 4 BG layers * 5
    localparam int C_MAP_WORDS   = 2048;
    localparam int C_TILE_WORDS  = 16384;  // 256 tiles * 64 pixels
    localparam int C_PAL_WORDS   = 256;
    localparam int C_MAP_W       = 16;
    localparam int C_TILE_W      = 8;

    typedef struct packed {
        logic         ok;       // address hits a populated word
        vram_region_e region;
    } vram_dec_t;

    // addr[23:22] must be zero so that region numbers 4..15 are rejected.
    function automatic vram_dec_t vram_decode(
        input logic [31:0] addr,
        input int          param_words,
        input int          map_words,
        input int          tile_words,
        input int          pal_words
    );
        vram_dec_t d;
        int        size;
        size     = 0;
        d.region = vram_region_e'(addr[21:20]);
        case (d.region)
            REG_PARAM: size = param_words;
            REG_MAP:   size = map_words;
            REG_TILE:  size = tile_words;
            REG_PAL:   size = pal_words;
            default:   size = 0;
        endcase
        d.ok = (addr[31:24] == C_VRAM_BASE[31:24]) &&
               (addr[23:22] == 2'b00) &&
               (int'({12'd0, addr[19:0]}) < size);
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_bus_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : vram_bus_responder_if
//  Purpose  : CPU and PPU access signals of the video-memory responder.
//             master : CPU/PPU side (drives strobes, addresses, write data)
//             slave  : responder side (returns registered read data)
//  Signals  : mem_en, mem_we, mem_addr[31:0], mem_din[31:0], mem_dout[31:0],
//             ppu_en, ppu_addr[31:0], ppu_dout[31:0]
//  Revision : 1.0 - initial release
// ============================================================================
interface vram_bus_responder_if;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        ppu_en;
    logic [31:0] ppu_addr;
    logic [31:0] ppu_dout;

    modport master (
        output mem_en, mem_we, mem_addr, mem_din, ppu_en, ppu_addr,
        input  mem_dout, ppu_dout
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_din, ppu_en, ppu_addr,
        output mem_dout, ppu_dout
    );
endinterface
`default_nettype wire

// File: rtl/vram_bus_responder_param_commit.sv
`default_nettype none
// ============================================================================
//  Module   : vram_bus_responder_param_commit
//  Purpose  : Synchronises vsync, detects its rising edge and walks a copy
//             pointer over every PARAM word (one word per cycle) so the top
//             level can move shadow contents into the live copy.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             vsync             - asynchronous vertical sync
//             commit_busy       - high exactly while the copy runs
//             copy_ptr          - word being copied this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module vram_bus_responder_param_commit
    import vram_bus_responder_pkg::*;
#(
    parameter int WORDS = C_PARAM_WORDS,
    parameter int PTR_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync,
    output logic             commit_busy,
    output logic [PTR_W-1:0] copy_ptr
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } commit_state_e;

    commit_state_e    r_state;
    logic             r_vs_meta;
    logic             r_vs_sync;
    logic             r_vs_prev;
    logic             r_busy;
    logic [PTR_W-1:0] r_ptr;
    logic             w_vs_rise;

    assign w_vs_rise = r_vs_sync & ~r_vs_prev;

    // A rising edge seen while copying is simply not looked at, so a second
    // vsync never restarts or lengthens a commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
            r_busy    <= 1'b0;
            r_ptr     <= '0;
        end else begin
            r_vs_meta <= vsync;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
            case (r_state)
                ST_IDLE: begin
                    if (w_vs_rise) begin
                        r_state <= ST_COPY;
                        r_busy  <= 1'b1;
                        r_ptr   <= '0;
                    end
                end
                ST_COPY: begin
                    if (r_ptr == PTR_W'(WORDS - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + PTR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign commit_busy = r_busy;
    assign copy_ptr    = r_ptr;

endmodule
`default_nettype wire

// File: rtl/vram_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : vram_bus_responder
//  Purpose  : Responder for the CPU memory bus over video memory. Decodes
//             the 0x06xx_xxxx window into PARAM/MAP/TILE/PAL stores, answers
//             CPU reads and serves a second read-only PPU port.
//  Ports    : clk, rst     - clock, synchronous active-high reset
//             vsync        - asynchronous vertical sync
//             bus          - vram_bus_responder_if.slave (CPU + PPU access)
//             commit_busy  - PARAM shadow->live copy in progress
//             err_count    - saturating count of CPU decode errors
//  Config   : VRAM_PARAM_SHADOW_EN - when defined, PARAM is double-buffered
//             (CPU sees shadow, PPU sees live) and committed on vsync;
//             otherwise a single PARAM store is shared and vsync is unused.
//  Revision : 1.0 - initial release
// ============================================================================
module vram_bus_responder
    import vram_bus_responder_pkg::*;
#(
    parameter int PARAM_WORDS = C_PARAM_WORDS,
    parameter int MAP_WORDS   = C_MAP_WORDS,
    parameter int TILE_WORDS  = C_TILE_WORDS,
    parameter int PAL_WORDS   = C_PAL_WORDS,
    parameter int MAP_W       = C_MAP_W,
    parameter int TILE_W      = C_TILE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vsync,
    vram_bus_responder_if.slave   bus,
    output logic                  commit_busy,
    output logic [15:0]           err_count
);

    localparam int PIDX = $clog2(PARAM_WORDS);
    localparam int MIDX = $clog2(MAP_WORDS);
    localparam int TIDX = $clog2(TILE_WORDS);
    localparam int LIDX = $clog2(PAL_WORDS);

    vram_dec_t w_cpu_dec;
    vram_dec_t w_ppu_dec;
    logic      w_cpu_wr;
    logic      w_cpu_err;

    assign w_cpu_dec = vram_decode(bus.mem_addr, PARAM_WORDS, MAP_WORDS, TILE_WORDS, PAL_WORDS);
    assign w_ppu_dec = vram_decode(bus.ppu_addr, PARAM_WORDS, MAP_WORDS, TILE_WORDS, PAL_WORDS);
    assign w_cpu_wr  = bus.mem_en & bus.mem_we & w_cpu_dec.ok;
    assign w_cpu_err = bus.mem_en & ~w_cpu_dec.ok;

    // Storage: contents are deliberately not reset.
    logic [31:0]       r_param_shadow [PARAM_WORDS];
    logic [MAP_W-1:0]  r_map          [MAP_WORDS];
    logic [TILE_W-1:0] r_tile         [TILE_WORDS];
    logic [31:0]       r_pal          [PAL_WORDS];

    always_ff @(posedge clk) begin
        if (w_cpu_wr) begin
            case (w_cpu_dec.region)
                REG_PARAM: r_param_shadow[bus.mem_addr[PIDX-1:0]] <= bus.mem_din;
                REG_MAP:   r_map[bus.mem_addr[MIDX-1:0]]          <= bus.mem_din[MAP_W-1:0];
                REG_TILE:  r_tile[bus.mem_addr[TIDX-1:0]]         <= bus.mem_din[TILE_W-1:0];
                REG_PAL:   r_pal[bus.mem_addr[LIDX-1:0]]          <= bus.mem_din;
                default:   ;
            endcase
        end
    end

    logic [31:0] w_ppu_param;

`ifdef VRAM_PARAM_SHADOW_EN
    logic [31:0]     r_param_live [PARAM_WORDS];
    logic [PIDX-1:0] w_copy_ptr;
    logic            w_copying;
    logic            w_fwd;

    vram_bus_responder_param_commit #(
        .WORDS (PARAM_WORDS),
        .PTR_W (PIDX)
    ) u_commit (
        .clk         (clk),
        .rst         (rst),
        .vsync       (vsync),
        .commit_busy (w_copying),
        .copy_ptr    (w_copy_ptr)
    );

    // A CPU write landing on the very word being copied this cycle must be
    // part of this commit, so forward it instead of the stale shadow word.
    assign w_fwd = w_cpu_wr && (w_cpu_dec.region == REG_PARAM) &&
                   (bus.mem_addr[PIDX-1:0] == w_copy_ptr);

    always_ff @(posedge clk) begin
        if (w_copying) begin
            r_param_live[w_copy_ptr] <= w_fwd ? bus.mem_din : r_param_shadow[w_copy_ptr];
        end
    end

    assign commit_busy = w_copying;
    assign w_ppu_param = r_param_live[bus.ppu_addr[PIDX-1:0]];
`else
    logic w_unused_vsync;

    assign w_unused_vsync = vsync;
    assign commit_busy    = 1'b0;
    assign w_ppu_param    = r_param_shadow[bus.ppu_addr[PIDX-1:0]];
`endif

    // Read muxes; undecodable addresses read as zero.
    logic [31:0] w_cpu_rdata;
    logic [31:0] w_ppu_rdata;

    always_comb begin
        w_cpu_rdata = '0;
        if (w_cpu_dec.ok) begin
            case (w_cpu_dec.region)
                REG_PARAM: w_cpu_rdata = r_param_shadow[bus.mem_addr[PIDX-1:0]];
                REG_MAP:   w_cpu_rdata = {{(32-MAP_W){1'b0}}, r_map[bus.mem_addr[MIDX-1:0]]};
                REG_TILE:  w_cpu_rdata = {{(32-TILE_W){1'b0}}, r_tile[bus.mem_addr[TIDX-1:0]]};
                REG_PAL:   w_cpu_rdata = r_pal[bus.mem_addr[LIDX-1:0]];
                default:   w_cpu_rdata = '0;
            endcase
        end
    end

    always_comb begin
        w_ppu_rdata = '0;
        if (w_ppu_dec.ok) begin
            case (w_ppu_dec.region)
                REG_PARAM: w_ppu_rdata = w_ppu_param;
                REG_MAP:   w_ppu_rdata = {{(32-MAP_W){1'b0}}, r_map[bus.ppu_addr[MIDX-1:0]]};
                REG_TILE:  w_ppu_rdata = {{(32-TILE_W){1'b0}}, r_tile[bus.ppu_addr[TIDX-1:0]]};
                REG_PAL:   w_ppu_rdata = r_pal[bus.ppu_addr[LIDX-1:0]];
                default:   w_ppu_rdata = '0;
            endcase
        end
    end

    logic [31:0] r_mem_dout;
    logic [31:0] r_ppu_dout;
    logic [15:0] r_err_count;

    // Read data is registered and held while the strobe is low; a write in
    // the same cycle as a read returns the pre-write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_dout  <= '0;
            r_ppu_dout  <= '0;
            r_err_count <= '0;
        end else begin
            if (bus.mem_en && !bus.mem_we) begin
                r_mem_dout <= w_cpu_rdata;
            end
            if (bus.ppu_en) begin
                r_ppu_dout <= w_ppu_rdata;
            end
            if (w_cpu_err && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign bus.mem_dout = r_mem_dout;
    assign bus.ppu_dout = r_ppu_dout;
    assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_vram_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vram_bus_responder
//  Purpose  : Self-checking bench for vram_bus_responder. A sparse model of
//             the address map (associative arrays keyed by CPU address)
//             predicts every read and the error counter.
//  Config   : VRAM_PARAM_SHADOW_EN selects the double-buffered PARAM tests.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vram_bus_responder;
    import vram_bus_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic        commit_busy;
    logic [15:0] err_count;

    vram_bus_responder_if bus ();

    vram_bus_responder dut (
        .clk         (clk),
        .rst         (rst),
        .vsync       (vsync),
        .bus         (bus),
        .commit_busy (commit_busy),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [31:0] m_cpu  [int unsigned];   // what the CPU reads back
    logic [31:0] m_live [int unsigned];   // PARAM words the PPU sees (shadow build)
    logic [31:0] wq[$];                   // valid addresses written so far
    int unsigned m_err = 0;

    localparam logic [31:0] P0   = 32'h0600_0000;
    localparam logic [31:0] P50  = 32'h0600_0032;
    localparam logic [31:0] P200 = 32'h0600_00C8;
    localparam logic [31:0] P300 = 32'h0600_012C;

    function automatic int unsigned rwords(input int unsigned r);
        case (r)
            0:       return 660;
            1:       return 2048;
            2:       return 16384;
            3:       return 256;
            default: return 0;
        endcase
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return (a[31:24] == 8'h06) && (int'(a[19:0]) < int'(rwords(a[23:20])));
    endfunction

    function automatic logic [31:0] mask_data(input logic [31:0] a, input logic [31:0] d);
        if (a[23:20] == 4'd1) return d & 32'h0000_FFFF;
        if (a[23:20] == 4'd2) return d & 32'h0000_00FF;
        return d;
    endfunction

    function automatic void model_access(input logic [31:0] a, input bit we, input logic [31:0] d);
        if (!addr_ok(a)) begin
            if (m_err < 65535) m_err++;
        end else if (we) begin
            m_cpu[a] = mask_data(a, d);
            wq.push_back(a);
        end
    endfunction

    function automatic void exp_cpu(input logic [31:0] a, output logic [31:0] v, output bit known);
        v = '0;
        known = 1'b1;
        if (addr_ok(a)) begin
            known = m_cpu.exists(a);
            if (known) v = m_cpu[a];
        end
    endfunction

    function automatic void exp_ppu(input logic [31:0] a, output logic [31:0] v, output bit known);
        v = '0;
        known = 1'b1;
        if (addr_ok(a)) begin
`ifdef VRAM_PARAM_SHADOW_EN
            if (a[23:20] == 4'd0) begin
                known = m_live.exists(a);
                if (known) v = m_live[a];
            end else begin
                known = m_cpu.exists(a);
                if (known) v = m_cpu[a];
            end
`else
            known = m_cpu.exists(a);
            if (known) v = m_cpu[a];
`endif
        end
    endfunction

    function automatic logic [31:0] rand_addr(input bit allow_err);
        int unsigned r;
        int unsigned off;
        logic [31:0] a;
        r   = $urandom_range(0, 3);
        off = $urandom_range(0, rwords(r) - 1);
        a   = {8'h06, 4'(r), 20'(off)};
        if (allow_err && ($urandom_range(0, 9) == 0)) begin
            case ($urandom_range(0, 2))
                0:       a = {8'h07, 4'(r), 20'(off)};
                1:       a = {8'h06, 4'($urandom_range(4, 15)), 20'(off)};
                default: a = {8'h06, 4'(r), 20'(rwords(r) + $urandom_range(0, 50))};
            endcase
        end
        return a;
    endfunction

    // Stimulus is applied 1 time unit after a rising edge; results are
    // sampled 1 time unit after the following rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit ce, input bit we, input logic [31:0] a, input logic [31:0] d,
                          input bit pe, input logic [31:0] pa,
                          output logic [31:0] mq, output logic [31:0] pq);
        bus.mem_en   = ce;
        bus.mem_we   = we;
        bus.mem_addr = a;
        bus.mem_din  = d;
        bus.ppu_en   = pe;
        bus.ppu_addr = pa;
        cycle();
        bus.mem_en = 1'b0;
        bus.mem_we = 1'b0;
        bus.ppu_en = 1'b0;
        mq = bus.mem_dout;
        pq = bus.ppu_dout;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mq, pq;
        access(1'b1, 1'b1, a, d, 1'b0, 32'h0, mq, pq);
        model_access(a, 1'b1, d);
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] q);
        logic [31:0] pq;
        access(1'b1, 1'b0, a, 32'h0, 1'b0, 32'h0, q, pq);
        model_access(a, 1'b0, 32'h0);
    endtask

    task automatic ppu_read(input logic [31:0] a, output logic [31:0] q);
        logic [31:0] mq;
        access(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, a, mq, q);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cycle();
        checks++; if (bus.mem_dout !== 32'h0) begin errors++; $display("FAIL reset_mem_dout: got %h expected 0", bus.mem_dout); end
        checks++; if (bus.ppu_dout !== 32'h0) begin errors++; $display("FAIL reset_ppu_dout: got %h expected 0", bus.ppu_dout); end
        checks++; if (commit_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", commit_busy); end
        checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err: got %h expected 0", err_count); end
        rst = 1'b0;
        m_err = 0;
        cycle();
    endtask

    task automatic test_directed();
        logic [31:0] q;
        cpu_write(C_PAL_BASE + 32'd3, 32'hFFFF_0000);
        cpu_read(C_PAL_BASE + 32'd3, q);
        checks++; if (q !== 32'hFFFF_0000) begin errors++; $display("FAIL pal3_read: got %h expected ffff0000", q); end
        cycle();
        checks++; if (bus.mem_dout !== 32'hFFFF_0000) begin errors++; $display("FAIL dout_hold: got %h expected ffff0000", bus.mem_dout); end
        cpu_write(C_MAP_BASE + 32'd5, 32'h1234_00AB);
        cpu_read(C_MAP_BASE + 32'd5, q);
        checks++; if (q !== 32'h0000_00AB) begin errors++; $display("FAIL map5_read: got %h expected 000000ab", q); end
        cpu_write(C_TILE_BASE + 32'd100, 32'h0000_01FF);
        cpu_read(C_TILE_BASE + 32'd100, q);
        checks++; if (q !== 32'h0000_00FF) begin errors++; $display("FAIL tile100_read: got %h expected 000000ff", q); end
        ppu_read(C_MAP_BASE + 32'd5, q);
        checks++; if (q !== 32'h0000_00AB) begin errors++; $display("FAIL ppu_map5: got %h expected 000000ab", q); end
    endtask

    task automatic test_errors();
        logic [31:0] q, mq, pq, base, d;
        rst = 1'b1; cycle(); rst = 1'b0; m_err = 0;
        cpu_read(C_PAL_BASE + 32'd3, q);
        cpu_write(32'h0640_0000, 32'hDEAD_BEEF);
        cpu_read(32'h0630_0100, q);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL err_read_zero: got %h expected 0", q); end
        checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL err_count_two: got %0d expected 2", err_count); end
        for (int r = 0; r < 4; r++) begin
            base = {8'h06, 4'(r), 20'h0};
            d = $urandom();
            cpu_write(base + rwords(r) - 1, d);
            cpu_read(base + rwords(r) - 1, q);
            checks++; if (q !== mask_data(base, d)) begin errors++; $display("FAIL last_word_r%0d: got %h expected %h", r, q, mask_data(base, d)); end
            cpu_read(base + rwords(r), q);
            checks++; if (q !== 32'h0) begin errors++; $display("FAIL past_end_r%0d: got %h expected 0", r, q); end
        end
        checks++; if (err_count !== 16'(m_err)) begin errors++; $display("FAIL err_count_bounds: got %0d expected %0d", err_count, m_err); end
        access(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0700_0000, mq, pq);
        checks++; if (pq !== 32'h0) begin errors++; $display("FAIL ppu_err_zero: got %h expected 0", pq); end
        checks++; if (err_count !== 16'(m_err)) begin errors++; $display("FAIL ppu_err_uncounted: got %0d expected %0d", err_count, m_err); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] mq, pq, q;
        cpu_write(C_PAL_BASE + 32'd10, 32'h1357_9BDF);
        access(1'b1, 1'b1, C_PAL_BASE + 32'd10, 32'h2468_ACE0, 1'b1, C_PAL_BASE + 32'd10, mq, pq);
        model_access(C_PAL_BASE + 32'd10, 1'b1, 32'h2468_ACE0);
        checks++; if (pq !== 32'h1357_9BDF) begin errors++; $display("FAIL same_cycle_old: got %h expected 13579bdf", pq); end
        ppu_read(C_PAL_BASE + 32'd10, q);
        checks++; if (q !== 32'h2468_ACE0) begin errors++; $display("FAIL after_write_new: got %h expected 2468ace0", q); end
    endtask

`ifdef VRAM_PARAM_SHADOW_EN
    // Pulses vsync and measures how many sample points commit_busy is high.
    task automatic run_commit(output int busy_cycles);
        int k;
        busy_cycles = 0;
        vsync = 1'b1;
        k = 0;
        while (commit_busy !== 1'b1 && k < 5) begin cycle(); k++; end
        vsync = 1'b0;
        checks++;
        if (commit_busy !== 1'b1) begin
            errors++; $display("FAIL commit_start: busy=%b after %0d cycles, required 1", commit_busy, k);
            return;
        end
        k = 0;
        while (commit_busy === 1'b1 && k < 2000) begin busy_cycles++; cycle(); k++; end
        foreach (m_cpu[a]) if (a[23:20] == 4'd0) m_live[a] = m_cpu[a];
    endtask

    task automatic test_param();
        logic [31:0] q;
        int n;
        cpu_write(P0, 32'h1111_2222);
        cpu_write(P0 + 32'd659, 32'h3333_4444);
        run_commit(n);
        ppu_read(P0, q);
        checks++; if (q !== 32'h1111_2222) begin errors++; $display("FAIL live_p0: got %h expected 11112222", q); end
        ppu_read(P0 + 32'd659, q);
        checks++; if (q !== 32'h3333_4444) begin errors++; $display("FAIL live_p659: got %h expected 33334444", q); end
        cpu_write(P0, 32'h8000_0A0A);
        ppu_read(P0, q);
        checks++; if (q !== 32'h1111_2222) begin errors++; $display("FAIL ppu_before_vsync: got %h expected 11112222", q); end
        cpu_read(P0, q);
        checks++; if (q !== 32'h8000_0A0A) begin errors++; $display("FAIL cpu_shadow: got %h expected 80000a0a", q); end
        run_commit(n);
        checks++; if (n != 660) begin errors++; $display("FAIL busy_len: got %0d expected 660", n); end
        ppu_read(P0, q);
        checks++; if (q !== 32'h8000_0A0A) begin errors++; $display("FAIL ppu_after_commit: got %h expected 80000a0a", q); end
    endtask

    task automatic test_midcopy();
        logic [31:0] q;
        int n, k;
        cpu_write(P50, 32'hA5A5_0050);
        cpu_write(P200, 32'hA5A5_0200);
        run_commit(n);
        vsync = 1'b1;
        k = 0;
        while (commit_busy !== 1'b1 && k < 5) begin cycle(); k++; end
        vsync = 1'b0;
        checks++; if (commit_busy !== 1'b1) begin errors++; $display("FAIL mid_start: busy=%b required 1", commit_busy); end
        // Sample point k has the copy pointer at k.
        n = 1; k = 0;
        while (commit_busy === 1'b1 && k < 2000) begin
            bus.mem_en   = (k == 100) || (k == 101);
            bus.mem_we   = (k == 100) || (k == 101);
            bus.mem_addr = (k == 100) ? P50 : P200;
            bus.mem_din  = (k == 100) ? 32'd1 : 32'd2;
            vsync        = (k >= 300) && (k < 306);
            cycle(); k++;
            bus.mem_en = 1'b0; bus.mem_we = 1'b0; vsync = 1'b0;
            if (commit_busy === 1'b1) n++;
        end
        m_cpu[P50] = 32'd1; m_cpu[P200] = 32'd2; m_live[P200] = 32'd2;
        checks++; if (n != 660) begin errors++; $display("FAIL mid_busy_len: got %0d expected 660", n); end
        repeat (6) cycle();
        checks++; if (commit_busy !== 1'b0) begin errors++; $display("FAIL no_restart: busy=%b required 0", commit_busy); end
        ppu_read(P200, q);
        checks++; if (q !== 32'd2) begin errors++; $display("FAIL mid_p200: got %h expected 2", q); end
        ppu_read(P50, q);
        checks++; if (q !== 32'hA5A5_0050) begin errors++; $display("FAIL mid_p50_old: got %h expected a5a50050", q); end
        run_commit(n);
        ppu_read(P50, q);
        checks++; if (q !== 32'd1) begin errors++; $display("FAIL next_p50: got %h expected 1", q); end
    endtask
`else
    task automatic test_param();
        logic [31:0] q;
        bit seen;
        cpu_write(P0 + 32'd7, 32'h0BAD_F00D);
        ppu_read(P0 + 32'd7, q);
        checks++; if (q !== 32'h0BAD_F00D) begin errors++; $display("FAIL param_direct: got %h expected 0badf00d", q); end
        seen = 1'b0;
        vsync = 1'b1;
        repeat (8) begin cycle(); if (commit_busy !== 1'b0) seen = 1'b1; end
        vsync = 1'b0;
        checks++; if (seen) begin errors++; $display("FAIL busy_tied: got 1 expected 0"); end
    endtask

    task automatic test_midcopy();
        logic [31:0] q;
        cpu_write(P0 + 32'd659, 32'h7777_0001);
        cpu_read(P0 + 32'd659, q);
        checks++; if (q !== 32'h7777_0001) begin errors++; $display("FAIL param_last: got %h expected 77770001", q); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] a, d, pa, mq, pq, em, ep, v;
        bit ce, we, pe, emk, epk, k;
        emk = 1'b0; epk = 1'b0; em = '0; ep = '0;
        for (int i = 0; i < 400; i++) begin
            ce = ($urandom_range(0, 3) != 0);
            we = $urandom_range(0, 1) == 1;
            if (!we && wq.size() > 0 && $urandom_range(0, 3) != 0) a = wq[$urandom_range(0, wq.size() - 1)];
            else a = rand_addr(1'b1);
            d  = $urandom();
            pe = $urandom_range(0, 1) == 1;
            if (wq.size() > 0 && $urandom_range(0, 3) != 0) pa = wq[$urandom_range(0, wq.size() - 1)];
            else pa = rand_addr(1'b1);
            if (ce && !we) begin exp_cpu(a, v, k); em = v; emk = k; end
            if (pe) begin exp_ppu(pa, v, k); ep = v; epk = k; end
            access(ce, we, a, d, pe, pa, mq, pq);
            if (ce) model_access(a, we, d);
            if (emk) begin checks++; if (mq !== em) begin errors++; $display("FAIL rand_cpu[%0d] addr %h: got %h expected %h", i, a, mq, em); end end
            if (epk) begin checks++; if (pq !== ep) begin errors++; $display("FAIL rand_ppu[%0d] addr %h: got %h expected %h", i, pa, pq, ep); end end
        end
        checks++; if (err_count !== 16'(m_err)) begin errors++; $display("FAIL rand_err_count: got %0d expected %0d", err_count, m_err); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] q;
        int k;
        cpu_read(32'h0700_0000, q);
        ppu_read(C_PAL_BASE + 32'd3, q);
        cpu_read(C_MAP_BASE + 32'd5, q);
`ifdef VRAM_PARAM_SHADOW_EN
        cpu_write(P300, 32'h0000_CAFE);
        run_commit(k);
        cpu_write(P300, 32'h0000_BEEF);
        vsync = 1'b1;
        k = 0;
        while (commit_busy !== 1'b1 && k < 5) begin cycle(); k++; end
        vsync = 1'b0;
        repeat (50) cycle();
        checks++; if (commit_busy !== 1'b1) begin errors++; $display("FAIL busy_before_rst: got %b expected 1", commit_busy); end
`endif
        rst = 1'b1;
        cycle();
        checks++; if (commit_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", commit_busy); end
        checks++; if (bus.mem_dout !== 32'h0) begin errors++; $display("FAIL rst_mem_dout: got %h expected 0", bus.mem_dout); end
        checks++; if (bus.ppu_dout !== 32'h0) begin errors++; $display("FAIL rst_ppu_dout: got %h expected 0", bus.ppu_dout); end
        checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL rst_err: got %h expected 0", err_count); end
        rst = 1'b0;
        m_err = 0;
        cycle();
`ifdef VRAM_PARAM_SHADOW_EN
        run_commit(k);
        checks++; if (k != 660) begin errors++; $display("FAIL recopy_len: got %0d expected 660", k); end
        ppu_read(P300, q);
        checks++; if (q !== 32'h0000_BEEF) begin errors++; $display("FAIL recopy_p300: got %h expected 0000beef", q); end
`endif
    endtask

    task automatic test_err_saturation();
        bus.mem_en   = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h0700_0000;
        for (int i = 0; i < 65534; i++) cycle();
        checks++; if (err_count !== 16'hFFFE) begin errors++; $display("FAIL err_fffe: got %h expected fffe", err_count); end
        cycle();
        checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL err_ffff: got %h expected ffff", err_count); end
        cycle(); cycle();
        checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL err_saturate: got %h expected ffff", err_count); end
        bus.mem_en = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        vsync        = 1'b0;
        bus.mem_en   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        bus.ppu_en   = 1'b0;
        bus.ppu_addr = '0;
        test_reset();
        test_directed();
        test_errors();
        test_same_cycle();
        test_param();
        test_midcopy();
        test_random();
        test_reset_midrun();
        test_err_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
